// File: rtl/nabp_filtered_ram_swap_control_pkg.sv
// Shared widths and encodings for the filtered-RAM double-buffer swap control.
package nabp_filtered_ram_swap_control_pkg;

  localparam int unsigned K_FILTERED_DATA_LENGTH = 16;
  localparam int unsigned K_S_LENGTH             = 9;
  localparam int unsigned K_ANGLE_LENGTH         = 9;
  localparam int unsigned NUM_BANKS              = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_HELD    = 2'd3
  } bank_state_e;

  typedef enum logic {
    N_IDLE = 1'b0,
    N_ACK  = 1'b1
  } next_fsm_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rel_fsm_e;

  // A bank may accept filter writes only before it has been completed.
  function automatic logic bank_fillable(input bank_state_e s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/nabp_filtered_bank_ram.sv
// Two-bank sample store: one write port, two registered read ports on a shared read bank.
module nabp_filtered_bank_ram
  import nabp_filtered_ram_swap_control_pkg::*;
#(
  parameter int unsigned DATA_W = K_FILTERED_DATA_LENGTH,
  parameter int unsigned ADDR_W = K_S_LENGTH,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data
);

  localparam int unsigned LIM_W = ADDR_W + 1;
  localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(DEPTH);

  logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

  logic wr_in_range;
  logic rd0_in_range;
  logic rd1_in_range;

  assign wr_in_range  = {1'b0, wr_addr}  < DEPTH_LIM;
  assign rd0_in_range = {1'b0, rd0_addr} < DEPTH_LIM;
  assign rd1_in_range = {1'b0, rd1_addr} < DEPTH_LIM;

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Out-of-range addresses read as zero rather than aliasing into the bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd0_data <= '0;
      rd1_data <= '0;
    end else begin
      rd0_data <= rd0_in_range ? mem[rd_bank][rd0_addr] : '0;
      rd1_data <= rd1_in_range ? mem[rd_bank][rd1_addr] : '0;
    end
  end

endmodule

// File: rtl/nabp_filtered_ram_swap_control.sv
// Producer side of the filtered-RAM angle handshake: double-buffers filter lines and
// hands them out on four-phase next/release handshakes.
module nabp_filtered_ram_swap_control
  import nabp_filtered_ram_swap_control_pkg::*;
#(
  parameter int unsigned pDataLength  = K_FILTERED_DATA_LENGTH,
  parameter int unsigned pSLength     = K_S_LENGTH,
  parameter int unsigned pAngleLength = K_ANGLE_LENGTH,
  parameter int unsigned pDepth       = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fl_wr_en,
  input  logic [pSLength-1:0]     fl_wr_addr,
  input  logic [pDataLength-1:0]  fl_wr_data,
  input  logic [pAngleLength-1:0] fl_angle,
  input  logic                    fl_done,
  input  logic                    fl_has_next_angle,
  output logic                    fl_ready,
  input  logic                    fr_next_angle,
  output logic                    fr_next_angle_ack,
  input  logic                    fr_prev_angle_release,
  output logic                    fr_prev_angle_release_ack,
  output logic                    fr_has_next_angle,
  output logic [pAngleLength-1:0] fr_angle,
  input  logic [pSLength-1:0]     fr0_s_val,
  input  logic [pSLength-1:0]     fr1_s_val,
  output logic [pDataLength-1:0]  fr0_val,
  output logic [pDataLength-1:0]  fr1_val
);

  bank_state_e             bank_state [NUM_BANKS];
  logic [pAngleLength-1:0] angle_reg  [NUM_BANKS];
  logic                    wr_ptr;
  logic                    grant_ptr;
  logic                    rel_ptr;
  logic                    cur_bank;
  next_fsm_e               next_fsm;
  rel_fsm_e                rel_fsm;

  logic wr_fire;
  logic done_fire;
  logic grant_fire;
  logic rel_fire;
  logic rel_frees;
  logic any_pending;

  assign fl_ready   = bank_fillable(bank_state[wr_ptr]);
  assign wr_fire    = fl_wr_en & fl_ready;
  assign done_fire  = fl_done & fl_ready;
  assign grant_fire = (next_fsm == N_IDLE) & fr_next_angle & (bank_state[grant_ptr] == BANK_FULL);
  assign rel_fire   = (rel_fsm == R_IDLE) & fr_prev_angle_release;
  assign rel_frees  = rel_fire & (bank_state[rel_ptr] == BANK_HELD);

  always_comb begin
    any_pending = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_state[b] == BANK_FILLING || bank_state[b] == BANK_FULL) begin
        any_pending = 1'b1;
      end
    end
  end

  // Each event needs a distinct source state, so at most one applies per bank per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state[b] <= BANK_EMPTY;
        angle_reg[b]  <= '0;
      end
      wr_ptr <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rel_frees && rel_ptr == 1'(b)) begin
          bank_state[b] <= BANK_EMPTY;
        end else if (grant_fire && grant_ptr == 1'(b)) begin
          bank_state[b] <= BANK_HELD;
        end else if (done_fire && wr_ptr == 1'(b)) begin
          bank_state[b] <= BANK_FULL;
        end else if (wr_fire && wr_ptr == 1'(b) && bank_state[b] == BANK_EMPTY) begin
          bank_state[b] <= BANK_FILLING;
        end
      end
      if (done_fire) begin
        angle_reg[wr_ptr] <= fl_angle;
        wr_ptr            <= ~wr_ptr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_fsm          <= N_IDLE;
      fr_next_angle_ack <= 1'b0;
      fr_angle          <= '0;
      grant_ptr         <= 1'b0;
      cur_bank          <= 1'b0;
    end else begin
      case (next_fsm)
        N_IDLE: begin
          if (grant_fire) begin
            fr_next_angle_ack <= 1'b1;
            fr_angle          <= angle_reg[grant_ptr];
            cur_bank          <= grant_ptr;
            grant_ptr         <= ~grant_ptr;
            next_fsm          <= N_ACK;
          end
        end
        N_ACK: begin
          if (!fr_next_angle) begin
            fr_next_angle_ack <= 1'b0;
            next_fsm          <= N_IDLE;
          end
        end
      endcase
    end
  end

  // A release with nothing held is still acknowledged but leaves the banks alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rel_fsm                   <= R_IDLE;
      fr_prev_angle_release_ack <= 1'b0;
      rel_ptr                   <= 1'b0;
    end else begin
      case (rel_fsm)
        R_IDLE: begin
          if (rel_fire) begin
            fr_prev_angle_release_ack <= 1'b1;
            rel_fsm                   <= R_ACK;
            if (rel_frees) begin
              rel_ptr <= ~rel_ptr;
            end
          end
        end
        R_ACK: begin
          if (!fr_prev_angle_release) begin
            fr_prev_angle_release_ack <= 1'b0;
            rel_fsm                   <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr_has_next_angle <= 1'b0;
    end else begin
      fr_has_next_angle <= fl_has_next_angle | any_pending;
    end
  end

  nabp_filtered_bank_ram #(
    .DATA_W (pDataLength),
    .ADDR_W (pSLength),
    .DEPTH  (pDepth)
  ) u_bank_ram (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_fire),
    .wr_bank  (wr_ptr),
    .wr_addr  (fl_wr_addr),
    .wr_data  (fl_wr_data),
    .rd_bank  (cur_bank),
    .rd0_addr (fr0_s_val),
    .rd1_addr (fr1_s_val),
    .rd0_data (fr0_val),
    .rd1_data (fr1_val)
  );

endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Scoreboard bench for the filtered-RAM swap control: handshakes, bank guarding, reads.
module tb_nabp_filtered_ram_swap_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fl_wr_en = 1'b0;
  logic [8:0]  fl_wr_addr = '0;
  logic [15:0] fl_wr_data = '0;
  logic [8:0]  fl_angle = '0;
  logic        fl_done = 1'b0;
  logic        fl_has_next_angle = 1'b0;
  logic        fl_ready;
  logic        fr_next_angle = 1'b0;
  logic        fr_next_angle_ack;
  logic        fr_prev_angle_release = 1'b0;
  logic        fr_prev_angle_release_ack;
  logic        fr_has_next_angle;
  logic [8:0]  fr_angle;
  logic [8:0]  fr0_s_val = '0;
  logic [8:0]  fr1_s_val = '0;
  logic [15:0] fr0_val;
  logic [15:0] fr1_val;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
  } rd_exp_t;

  rd_exp_t sb[$];
  logic rd_issue = 1'b0;
  logic rd_valid_d = 1'b0;

  always #5 clk = ~clk;

  nabp_filtered_ram_swap_control dut (
    .clk                       (clk),
    .reset                     (reset),
    .fl_wr_en                  (fl_wr_en),
    .fl_wr_addr                (fl_wr_addr),
    .fl_wr_data                (fl_wr_data),
    .fl_angle                  (fl_angle),
    .fl_done                   (fl_done),
    .fl_has_next_angle         (fl_has_next_angle),
    .fl_ready                  (fl_ready),
    .fr_next_angle             (fr_next_angle),
    .fr_next_angle_ack         (fr_next_angle_ack),
    .fr_prev_angle_release     (fr_prev_angle_release),
    .fr_prev_angle_release_ack (fr_prev_angle_release_ack),
    .fr_has_next_angle         (fr_has_next_angle),
    .fr_angle                  (fr_angle),
    .fr0_s_val                 (fr0_s_val),
    .fr1_s_val                 (fr1_s_val),
    .fr0_val                   (fr0_val),
    .fr1_val                   (fr1_val)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read results arrive one cycle after the address is presented.
  always @(posedge clk) rd_valid_d <= rd_issue;

  always @(negedge clk) begin
    if (rd_valid_d) begin
      rd_exp_t e;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("fr0_val", 32'(fr0_val), 32'(e.e0));
        check_eq("fr1_val", 32'(fr1_val), 32'(e.e1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fl_wr_en = 1'b0; fl_done = 1'b0; fl_has_next_angle = 1'b0;
    fr_next_angle = 1'b0; fr_prev_angle_release = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic fill(input logic [8:0] angle, input int n, input logic [15:0] mask);
    for (int i = 0; i < n; i++) begin
      fl_wr_en = 1'b1; fl_wr_addr = 9'(i); fl_wr_data = 16'(i) ^ mask;
      tick();
    end
    fl_wr_en = 1'b0;
    fl_done = 1'b1; fl_angle = angle;
    tick();
    fl_done = 1'b0;
  endtask

  task automatic handshake(input bit rel, input string tag, output int lat);
    lat = -1;
    if (rel) fr_prev_angle_release = 1'b1; else fr_next_angle = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if ((rel ? fr_prev_angle_release_ack : fr_next_angle_ack) === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) check_eq({tag, "_timeout"}, 32'(rel ? fr_prev_angle_release_ack : fr_next_angle_ack), 32'd1);
    if (rel) fr_prev_angle_release = 1'b0; else fr_next_angle = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if ((rel ? fr_prev_angle_release_ack : fr_next_angle_ack) === 1'b0) break;
    end
    check_eq({tag, "_ack_drop"}, 32'(rel ? fr_prev_angle_release_ack : fr_next_angle_ack), 32'd0);
  endtask

  task automatic issue_read(input logic [8:0] a0, input logic [8:0] a1,
                            input logic [15:0] e0, input logic [15:0] e1);
    rd_exp_t e;
    fr0_s_val = a0; fr1_s_val = a1;
    e.e0 = e0; e.e1 = e1;
    sb.push_back(e);
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;

    // Reset values while reset is held.
    tick();
    check_eq("rst_next_ack", 32'(fr_next_angle_ack), 32'd0);
    check_eq("rst_rel_ack", 32'(fr_prev_angle_release_ack), 32'd0);
    check_eq("rst_fl_ready", 32'(fl_ready), 32'd1);
    check_eq("rst_fr_angle", 32'(fr_angle), 32'd0);
    check_eq("rst_has_next", 32'(fr_has_next_angle), 32'd0);
    check_eq("rst_fr0", 32'(fr0_val), 32'd0);
    check_eq("rst_fr1", 32'(fr1_val), 32'd0);

    // Full line into bank0, grant it, read two samples.
    do_reset();
    fill(9'd5, 512, 16'h0000);
    check_eq("t1_fl_ready", 32'(fl_ready), 32'd1);
    handshake(1'b0, "t1_next", lat);
    check_eq("t1_next_lat", 32'(lat), 32'd1);
    check_eq("t1_fr_angle", 32'(fr_angle), 32'd5);
    issue_read(9'd100, 9'd511, 16'd100, 16'd511);
    issue_read(9'd0, 9'd255, 16'd0, 16'd255);

    // Both banks held: writes ignored, release frees the older bank.
    do_reset();
    fill(9'd1, 512, 16'h0100);
    fill(9'd2, 512, 16'h2000);
    handshake(1'b0, "t2_next0", lat);
    check_eq("t2_angle0", 32'(fr_angle), 32'd1);
    check_eq("t2_ready_held_full", 32'(fl_ready), 32'd0);
    fl_wr_en = 1'b1; fl_wr_addr = 9'd10; fl_wr_data = 16'hFFFF;
    tick();
    fl_wr_en = 1'b0;
    issue_read(9'd10, 9'd11, 16'd10 ^ 16'h0100, 16'd11 ^ 16'h0100);
    handshake(1'b0, "t2_next1", lat);
    check_eq("t2_angle1", 32'(fr_angle), 32'd2);
    check_eq("t2_ready_both_held", 32'(fl_ready), 32'd0);
    fl_wr_en = 1'b1; fl_wr_addr = 9'd20; fl_wr_data = 16'hFFFF;
    tick();
    fl_wr_en = 1'b0;
    handshake(1'b1, "t2_rel", lat);
    check_eq("t2_rel_lat", 32'(lat), 32'd1);
    check_eq("t2_ready_after_rel", 32'(fl_ready), 32'd1);
    issue_read(9'd10, 9'd20, 16'd10 ^ 16'h2000, 16'd20 ^ 16'h2000);

    // Request with nothing full waits, then grants shortly after fl_done.
    do_reset();
    fr_next_angle = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fr_next_angle_ack === 1'b1) cnt++;
    end
    check_eq("t3_no_ack_20", 32'(cnt), 32'd0);
    fill(9'd7, 4, 16'h0000);
    lat = -1;
    for (int c = 1; c <= 4; c++) begin
      if (fr_next_angle_ack === 1'b1) begin
        lat = c - 1;
        break;
      end
      tick();
    end
    check_eq("t3_ack_within_2", 32'((lat >= 0) && (lat <= 1)), 32'd1);
    check_eq("t3_fr_angle", 32'(fr_angle), 32'd7);
    fr_next_angle = 1'b0;
    tick();
    check_eq("t3_ack_drop", 32'(fr_next_angle_ack), 32'd0);

    // fr_has_next_angle tracks pending banks and the filter flag, one cycle late.
    do_reset();
    tick();
    check_eq("t4_has_empty", 32'(fr_has_next_angle), 32'd0);
    fill(9'd6, 1, 16'h0000);
    handshake(1'b0, "t4_next", lat);
    tick();
    check_eq("t4_has_held", 32'(fr_has_next_angle), 32'd0);
    fl_wr_en = 1'b1; fl_wr_addr = 9'd0; fl_wr_data = 16'h1234;
    tick();
    fl_wr_en = 1'b0;
    check_eq("t4_has_lag", 32'(fr_has_next_angle), 32'd0);
    tick();
    check_eq("t4_has_filling", 32'(fr_has_next_angle), 32'd1);
    do_reset();
    fl_has_next_angle = 1'b1;
    tick();
    check_eq("t4_has_flag", 32'(fr_has_next_angle), 32'd1);
    fl_has_next_angle = 1'b0;

    // Asynchronous reset in the middle of an acknowledged handshake.
    do_reset();
    fill(9'd3, 2, 16'h0000);
    fr_next_angle = 1'b1;
    tick();
    check_eq("t5_ack_before", 32'(fr_next_angle_ack), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t5_async_ack", 32'(fr_next_angle_ack), 32'd0);
    check_eq("t5_async_ready", 32'(fl_ready), 32'd1);
    check_eq("t5_async_angle", 32'(fr_angle), 32'd0);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fr_next_angle_ack === 1'b1) cnt++;
    end
    check_eq("t5_wait_fresh", 32'(cnt), 32'd0);
    fill(9'd9, 2, 16'h0000);
    tick();
    check_eq("t5_ack_after", 32'(fr_next_angle_ack), 32'd1);
    check_eq("t5_angle_after", 32'(fr_angle), 32'd9);
    fr_next_angle = 1'b0;
    tick();
    check_eq("t5_ack_drop", 32'(fr_next_angle_ack), 32'd0);

    // Release with nothing held is acknowledged without moving the release pointer.
    do_reset();
    handshake(1'b1, "t6_rel_empty", lat);
    check_eq("t6_rel_lat", 32'(lat), 32'd1);
    check_eq("t6_ready", 32'(fl_ready), 32'd1);
    check_eq("t6_has", 32'(fr_has_next_angle), 32'd0);
    fill(9'd4, 2, 16'h0000);
    fill(9'd8, 2, 16'h0010);
    handshake(1'b0, "t6_next0", lat);
    check_eq("t6_angle0", 32'(fr_angle), 32'd4);
    handshake(1'b0, "t6_next1", lat);
    check_eq("t6_angle1", 32'(fr_angle), 32'd8);
    check_eq("t6_ready_full", 32'(fl_ready), 32'd0);
    handshake(1'b1, "t6_rel", lat);
    check_eq("t6_ready_freed", 32'(fl_ready), 32'd1);
    issue_read(9'd1, 9'd0, 16'h0011, 16'h0010);

    tick();
    tick();
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
